// File: rtl/board_engine_param.sv
// NxN 2048 board engine: board register, edge-triggered move sequencer (one line per cycle),
// merge/score datapath, LFSR tile spawner and win/lose detection.
module board_engine_param #(
  parameter int unsigned N       = 4,
  parameter int unsigned TW      = 4,
  parameter int unsigned WIN_EXP = 11,
  parameter int unsigned SCW     = 20,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        dir,
  input  logic              ld,
  input  logic [N*N*TW-1:0] ld_board,
  output logic [N*N*TW-1:0] board,
  output logic [SCW-1:0]    score,
  output logic [1:0]        endstatus,
  output logic              busy,
  output logic              moved
);

  localparam int unsigned NC = N * N;
  localparam int unsigned IW = $clog2(NC);
  localparam int unsigned LW = $clog2(N);
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned GW = (1 << TW) + LW + 1;
  localparam int unsigned AW = ((GW > SCW) ? GW : SCW) + 1;
  localparam logic [TW-1:0]  EMAX = {TW{1'b1}};
  localparam logic [SCW-1:0] SMAX = {SCW{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SPAWN, S_WAIT, S_MOVE, S_CHECK, S_END
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] cells    [NC];
  logic [TW-1:0] ld_cells [NC];
  logic [15:0]   lfsr, lfsr_nx;
  logic [3:0]    dir_d, mdir, rise;
  logic          one_rise;
  logic [LW-1:0] line;
  logic          changed;
  logic [1:0]    spawn_cnt;
  logic [IW-1:0] spawn_idx, entry_idx, spawn_nxt;
  logic [TW-1:0] spawn_val;

  // Board image <-> cell array; cell 0 (top-left) sits at the MSB end
  for (genvar k = 0; k < NC; k++) begin : g_pack
    assign board[(NC-k)*TW-1 -: TW] = cells[k];
    assign ld_cells[k]             = ld_board[(NC-k)*TW-1 -: TW];
  end

  // Position p of line i for a one-hot direction, in "slide toward p=0" order
  function automatic logic [IW-1:0] cell_at(input logic [3:0] d, input logic [LW-1:0] i,
                                            input logic [LW-1:0] p);
    int unsigned r, c;
    if (d[0]) begin
      r = 32'(i);             c = 32'(p);
    end else if (d[1]) begin
      r = 32'(i);             c = N - 1 - 32'(p);
    end else if (d[2]) begin
      r = N - 1 - 32'(p);     c = 32'(i);
    end else begin
      r = 32'(p);             c = 32'(i);
    end
    return IW'(r * N + c);
  endfunction

  function automatic logic busy_of(input state_t s);
    return (s == S_CLEAR) || (s == S_SPAWN) || (s == S_MOVE) || (s == S_CHECK);
  endfunction

  assign lfsr_nx   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign entry_idx = IW'(32'(lfsr[IW-1:0]) % NC);
  assign spawn_nxt = (spawn_idx == IW'(NC - 1)) ? '0 : spawn_idx + IW'(1);
  assign spawn_val = (lfsr[15:12] != 4'h0) ? TW'(1) : TW'(2);
  assign rise      = dir & ~dir_d;
  assign one_rise  = (rise != 4'h0) && ((rise & (rise - 4'h1)) == 4'h0);

  // Line datapath: gather, compact toward index 0, merge pairs once from index 0
  logic [TW-1:0] line_in [N];
  logic [TW-1:0] cmp     [N+1];
  logic [TW-1:0] mo      [N+1];
  logic [CW-1:0] nz, o;
  logic          skip, line_diff;
  logic [TW-1:0] ne;
  logic [GW-1:0] gain;
  logic [AW-1:0] score_sum;

  always_comb begin
    cmp       = '{default: '0};
    mo        = '{default: '0};
    nz        = '0;
    o         = '0;
    skip      = 1'b0;
    ne        = '0;
    gain      = '0;
    line_diff = 1'b0;
    for (int p = 0; p < N; p++) begin
      line_in[LW'(p)] = cells[cell_at(mdir, line, LW'(p))];
      if (line_in[LW'(p)] != '0) begin
        cmp[nz] = line_in[LW'(p)];
        nz      = nz + CW'(1);
      end
    end
    for (int p = 0; p < N; p++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (cmp[CW'(p)] != '0) begin
        if (cmp[CW'(p + 1)] == cmp[CW'(p)]) begin
          ne    = (cmp[CW'(p)] == EMAX) ? EMAX : cmp[CW'(p)] + TW'(1);
          mo[o] = ne;
          gain  = gain + (GW'(1) << ne);
          skip  = 1'b1;
        end else begin
          mo[o] = cmp[CW'(p)];
        end
        o = o + CW'(1);
      end
    end
    for (int p = 0; p < N; p++)
      if (line_in[LW'(p)] != mo[CW'(p)]) line_diff = 1'b1;
    score_sum = AW'(score) + AW'(gain);
  end

  // End-of-game detection over the whole board
  logic any_win, any_zero, any_pair, lose;

  always_comb begin
    any_win  = 1'b0;
    any_zero = 1'b0;
    any_pair = 1'b0;
    for (int k = 0; k < NC; k++) begin
      if (cells[IW'(k)] == TW'(WIN_EXP)) any_win = 1'b1;
      if (cells[IW'(k)] == '0) any_zero = 1'b1;
      if (((k % N) != (N - 1)) && (cells[IW'(k)] == cells[IW'(k + 1)])) any_pair = 1'b1;
      if ((k < NC - N) && (cells[IW'(k)] == cells[IW'(k + N)])) any_pair = 1'b1;
    end
    lose = !any_zero && !any_pair;
  end

  // Next-state selection; start wins over everything
  always_comb begin
    state_n = state;
    if (start) begin
      state_n = S_CLEAR;
    end else begin
      case (state)
        S_IDLE:  if (ld) state_n = S_CHECK;
        S_CLEAR: state_n = S_SPAWN;
        S_SPAWN: if ((cells[spawn_idx] == '0) && (spawn_cnt == 2'd1)) state_n = S_CHECK;
        S_WAIT:  if (ld) state_n = S_CHECK;
                 else if (one_rise) state_n = S_MOVE;
        S_MOVE:  if (line == LW'(N - 1)) state_n = (changed || line_diff) ? S_SPAWN : S_WAIT;
        S_CHECK: state_n = (any_win || lose) ? S_END : S_WAIT;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cells     <= '{default: '0};
      score     <= '0;
      endstatus <= 2'b00;
      busy      <= 1'b0;
      moved     <= 1'b0;
      lfsr      <= SEED;
      dir_d     <= 4'h0;
      mdir      <= 4'h0;
      line      <= '0;
      changed   <= 1'b0;
      spawn_cnt <= 2'd0;
      spawn_idx <= '0;
    end else begin
      state <= state_n;
      busy  <= busy_of(state_n);
      lfsr  <= lfsr_nx;
      dir_d <= dir;
      moved <= 1'b0;
      case (state)
        S_IDLE: if (!start && ld) cells <= ld_cells;
        S_CLEAR: begin
          cells     <= '{default: '0};
          score     <= '0;
          endstatus <= 2'b00;
          spawn_cnt <= 2'd2;
          spawn_idx <= entry_idx;
        end
        S_SPAWN: begin
          // Fill the probed cell if empty, otherwise walk to the next index
          if (cells[spawn_idx] == '0) begin
            cells[spawn_idx] <= spawn_val;
            spawn_cnt        <= spawn_cnt - 2'd1;
            spawn_idx        <= entry_idx;
          end else begin
            spawn_idx <= spawn_nxt;
          end
        end
        S_WAIT: begin
          if (!start && ld) begin
            cells <= ld_cells;
          end else if (!start && one_rise) begin
            mdir    <= dir;
            line    <= '0;
            changed <= 1'b0;
          end
        end
        S_MOVE: begin
          for (int p = 0; p < N; p++) cells[cell_at(mdir, line, LW'(p))] <= mo[CW'(p)];
          score   <= (score_sum > AW'(SMAX)) ? SMAX : SCW'(score_sum);
          changed <= changed || line_diff;
          line    <= line + LW'(1);
          if ((line == LW'(N - 1)) && (changed || line_diff) && !start) begin
            moved     <= 1'b1;
            spawn_cnt <= 2'd1;
            spawn_idx <= entry_idx;
          end
        end
        S_CHECK: endstatus <= any_win ? 2'b10 : (lose ? 2'b01 : 2'b00);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_engine_param.sv
// Randomized scoreboard bench for board_engine_param: a queue-based game model predicts each
// operation's result; a monitor compares whenever busy drops.
module tb_board_engine_param;

  localparam int N    = 4;
  localparam int TW   = 4;
  localparam int NC   = N * N;
  localparam int BW   = NC * TW;
  localparam int SCW  = 20;
  localparam int WIN  = 11;
  localparam int SMAX = (1 << SCW) - 1;

  typedef logic [BW-1:0] brd_t;
  typedef struct packed {
    brd_t b;
    int   score;
    int   spawns;
    int   moved;
  } exp_t;

  logic          clock, reset_n, start, ld, busy, moved;
  logic [3:0]    dir;
  brd_t          ld_board, board;
  logic [SCW-1:0] score;
  logic [1:0]    endstatus;

  exp_t q[$];
  brd_t m_board;
  int   m_score, m_end;
  int   n_chk, n_fail;

  board_engine_param #(.N(N), .TW(TW), .WIN_EXP(WIN), .SCW(SCW), .SEED(16'hACE1)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .dir(dir), .ld(ld),
    .ld_board(ld_board), .board(board), .score(score), .endstatus(endstatus),
    .busy(busy), .moved(moved)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int cget(input brd_t b, input int k);
    return int'(b[(NC-k)*TW-1 -: TW]);
  endfunction

  function automatic brd_t cset(input brd_t b, input int k, input int v);
    brd_t r = b;
    r[(NC-k)*TW-1 -: TW] = TW'(v);
    return r;
  endfunction

  function automatic brd_t row0(input int a, input int b, input int c, input int d);
    brd_t r = '0;
    r = cset(r, 0, a); r = cset(r, 1, b); r = cset(r, 2, c); r = cset(r, 3, d);
    return r;
  endfunction

  // Cell index of slot p of line i, slots ordered in the sliding direction
  function automatic int pos(input int d, input int i, input int p);
    case (d)
      0:       return i * N + p;
      1:       return i * N + (N - 1 - p);
      2:       return (N - 1 - p) * N + i;
      default: return p * N + i;
    endcase
  endfunction

  function automatic int end_of(input brd_t b);
    bit full = 1'b1, pair = 1'b0;
    for (int k = 0; k < NC; k++) begin
      if (cget(b, k) == WIN) return 2;
      if (cget(b, k) == 0) full = 1'b0;
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        if (c < N - 1 && cget(b, r*N+c) == cget(b, r*N+c+1)) pair = 1'b1;
        if (r < N - 1 && cget(b, r*N+c) == cget(b, (r+1)*N+c)) pair = 1'b1;
      end
    return (full && !pair) ? 1 : 0;
  endfunction

  // 2048 slide rule on lists: drop blanks, then fuse equal neighbours front to back
  task automatic model_move(input brd_t b, input int d, output brd_t nb, output int gain);
    int lst[$];
    int outl[$];
    int v, nv;
    nb = b; gain = 0;
    for (int i = 0; i < N; i++) begin
      lst.delete(); outl.delete();
      for (int p = 0; p < N; p++) if (cget(b, pos(d, i, p)) != 0) lst.push_back(cget(b, pos(d, i, p)));
      while (lst.size() > 0) begin
        v = lst.pop_front();
        if (lst.size() > 0 && lst[0] == v) begin
          void'(lst.pop_front());
          nv = (v == 15) ? 15 : v + 1;
          gain += (1 << nv);
          outl.push_back(nv);
        end else outl.push_back(v);
      end
      for (int p = 0; p < N; p++) nb = cset(nb, pos(d, i, p), (p < outl.size()) ? outl[p] : 0);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: each busy 1->0 completes the oldest queued operation
  initial begin
    bit   busy_p;
    int   mv, nd, a, x;
    bit   legal;
    exp_t e;
    brd_t done_b;
    busy_p = 1'b0; mv = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        busy_p = 1'b0; mv = 0;
      end else begin
        if (moved) mv++;
        if (busy_p && !busy) begin
          if (q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_op: actual=board %0h required=no operation", board);
          end else begin
            e = q.pop_front();
            nd = 0; legal = 1'b1; done_b = e.b;
            for (int k = 0; k < NC; k++) begin
              a = cget(board, k); x = cget(e.b, k);
              if (a != x) begin
                if (x == 0 && (a == 1 || a == 2)) begin nd++; done_b = cset(done_b, k, a); end
                else legal = 1'b0;
              end
            end
            n_chk++;
            if (!legal || nd != e.spawns) begin
              n_fail++;
              $display("FAIL board: actual=%0h required=%0h plus %0d spawned tiles", board, e.b, e.spawns);
            end
            chk("score", 64'(score), 64'(e.score));
            chk("endstatus", 64'(endstatus), 64'(end_of(done_b)));
            chk("moved_pulses", 64'(mv), 64'(e.moved));
            m_board = done_b; m_score = e.score; m_end = end_of(done_b);
          end
          mv = 0;
        end
        busy_p = busy;
      end
    end
  end

  task automatic wait_done(input string nm);
    int t = 0;
    while (q.size() != 0 && t < 400) begin @(posedge clock); t++; end
    if (q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL timeout_%s: actual=%0d pending required=0 pending", nm, q.size());
      q.delete();
    end
    repeat (2) @(posedge clock);
  endtask

  task automatic do_start();
    exp_t e;
    e.b = '0; e.score = 0; e.spawns = 2; e.moved = 0;
    q.push_back(e);
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    wait_done("start");
  endtask

  task automatic do_ld(input brd_t b);
    exp_t e;
    e.b = b; e.score = m_score; e.spawns = 0; e.moved = 0;
    q.push_back(e);
    @(posedge clock); #1 ld = 1'b1; ld_board = b;
    @(posedge clock); #1 ld = 1'b0;
    wait_done("ld");
  endtask

  task automatic do_move(input int d, input int hold);
    exp_t e;
    brd_t nb;
    int   gain, chg;
    model_move(m_board, d, nb, gain);
    chg = (nb != m_board) ? 1 : 0;
    e.b = nb; e.spawns = chg; e.moved = chg;
    e.score = (m_score + gain > SMAX) ? SMAX : m_score + gain;
    q.push_back(e);
    @(posedge clock); #1 dir = 4'(1 << d);
    repeat (hold) @(posedge clock);
    #1 dir = 4'h0;
    wait_done("move");
  endtask

  // Drive an input event that must be ignored, then confirm nothing moved
  task automatic expect_idle(input string nm, input int end_req);
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk({nm, "_board"}, 64'(board), 64'(m_board));
    chk({nm, "_end"}, 64'(endstatus), 64'(end_req));
    chk({nm, "_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    brd_t b;
    n_chk = 0; n_fail = 0;
    reset_n = 1'b0; start = 1'b0; dir = 4'h0; ld = 1'b0; ld_board = '0;
    m_board = '0; m_score = 0; m_end = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_board", 64'(board), 64'(0));
    chk("rst_score", 64'(score), 64'(0));
    chk("rst_end", 64'(endstatus), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_moved", 64'(moved), 64'(0));
    @(posedge clock); #1 reset_n = 1'b1;

    do_start();
    do_ld(row0(1, 1, 2, 0));
    do_move(0, 2);
    do_ld(row0(2, 0, 0, 0));
    do_move(0, 2);

    do_ld(row0(10, 10, 0, 0));
    do_move(1, 2);
    @(posedge clock); #1 dir = 4'b0001;
    @(posedge clock); #1 dir = 4'h0;
    @(posedge clock); #1 ld = 1'b1; ld_board = '0;
    @(posedge clock); #1 ld = 1'b0;
    expect_idle("end_hold", 2);
    do_start();

    b = '0;
    for (int k = 0; k < NC; k++) b = cset(b, k, (((k / N) + (k % N)) % 2 == 1) ? 2 : 1);
    do_ld(b);
    do_start();

    // Saturating tile merge and score saturation
    b = '0;
    for (int k = 0; k < NC; k++) b = cset(b, k, 15);
    for (int i = 0; i < 5; i++) begin
      do_ld(b);
      do_move(0, 2);
    end
    do_start();

    for (int it = 0; it < 40; it++) begin
      if (m_end != 0) do_start();
      b = '0;
      for (int k = 0; k < NC; k++)
        if (it % 5 == 4) b = cset(b, k, int'($urandom_range(1, 4)));
        else b = cset(b, k, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : 0);
      do_ld(b);
      for (int j = 0; j < 3; j++) if (m_end == 0) do_move(int'($urandom_range(0, 3)), 2);
    end
    if (m_end != 0) do_start();

    // Held direction moves once; a two-bit edge is ignored
    do_ld(row0(0, 1, 0, 0));
    do_move(0, 100);
    @(posedge clock); #1 dir = 4'b0011;
    expect_idle("dual_edge", m_end);
    @(posedge clock); #1 dir = 4'h0;
    repeat (2) @(posedge clock);

    // Reset in the middle of a move
    do_ld(row0(0, 1, 0, 2));
    @(posedge clock); #1 dir = 4'b0010;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b0; dir = 4'h0;
    @(negedge clock);
    chk("midmove_rst_board", 64'(board), 64'(0));
    chk("midmove_rst_score", 64'(score), 64'(0));
    chk("midmove_rst_busy", 64'(busy), 64'(0));
    chk("midmove_rst_moved", 64'(moved), 64'(0));
    m_board = '0; m_score = 0; m_end = 0;
    @(posedge clock); #1 reset_n = 1'b1;
    @(posedge clock); #1 dir = 4'b0001;
    @(posedge clock); #1 dir = 4'h0;
    expect_idle("idle_dir", 0);
    do_ld(row0(3, 3, 3, 3));
    do_move(2, 2);

    @(posedge clock);
    if (q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL queue_drain: actual=%0d pending required=0 pending", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
